// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, FSM state type and opcode-class helpers for the MEM stage.
package mem_stage_pkg;
    localparam logic [5:0] OP_LW  = 6'h10;
    localparam logic [5:0] OP_LH  = 6'h11;
    localparam logic [5:0] OP_LHU = 6'h12;
    localparam logic [5:0] OP_LB  = 6'h13;
    localparam logic [5:0] OP_LBU = 6'h14;
    localparam logic [5:0] OP_SW  = 6'h18;
    localparam logic [5:0] OP_SH  = 6'h19;
    localparam logic [5:0] OP_SB  = 6'h1A;

    typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE_MEM-side inputs and MEM_WB-side outputs of the MEM stage.
interface mem_stage_if #(parameter int DW = 32, parameter int IW = 32);
    logic          in_valid;
    logic [IW-1:0] in_inst;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_sdata;
    logic          stall;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_inst;
    logic          out_fault;

    modport master (output in_valid, in_inst, in_alu, in_sdata,
                    input  stall, out_valid, out_data, out_inst, out_fault);
    modport slave  (input  in_valid, in_inst, in_alu, in_sdata,
                    output stall, out_valid, out_data, out_inst, out_fault);
endinterface

// File: rtl/mem_stage_dm_ram.sv
// dm_ram: byte-enabled single-port data RAM with registered read data.
module dm_ram #(
    parameter int DMW = 8
) (
    input  logic           clk,
    input  logic [3:0]     we,
    input  logic [DMW-1:0] addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata
);
    logic [31:0] mem [2**DMW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; aligned loads/stores against dm_ram, loads stall one cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int IW  = 32,
    parameter int DMW = 8
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_inst_q, out_inst_d;
    logic          out_fault_q, out_fault_d;

    logic [5:0]    op;
    logic [1:0]    lane;
    logic          is_ld, is_st, mis, idle_go;
    logic [3:0]    be, we;
    logic [DW-1:0] wdata, rdata, ld_val;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    dm_ram #(.DMW(DMW)) u_ram (
        .clk  (clk),
        .we   (we),
        .addr (bus.in_alu[DMW+1:2]),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_comb begin
        op      = bus.in_inst[IW-1 -: 6];
        lane    = bus.in_alu[1:0];
        is_ld   = is_load_op(op);
        is_st   = is_store_op(op);
        mis     = (op == OP_LW || op == OP_SW) ? |lane :
                  (op inside {OP_LH, OP_LHU, OP_SH}) ? lane[0] : 1'b0;
        idle_go = state_q == IDLE && bus.in_valid;
        be      = op == OP_SW ? 4'hF : op == OP_SH ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
        we      = (idle_go && is_st && !mis) ? be : 4'h0;
        wdata   = op == OP_SW ? bus.in_sdata :
                  op == OP_SH ? {2{bus.in_sdata[15:0]}} : {4{bus.in_sdata[7:0]}};
        // Opcode of the held load picks lane and extension in LOAD_WAIT.
        byte_v  = rdata[8*lane +: 8];
        half_v  = lane[1] ? rdata[31:16] : rdata[15:0];
        ld_val  = op == OP_LH  ? {{(DW-16){half_v[15]}}, half_v} :
                  op == OP_LHU ? {{(DW-16){1'b0}}, half_v} :
                  op == OP_LB  ? {{(DW-8){byte_v[7]}}, byte_v} :
                  op == OP_LBU ? {{(DW-8){1'b0}}, byte_v} : rdata;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_inst_d  = out_inst_q;
        out_fault_d = out_fault_q;
        if (state_q == LOAD_WAIT) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            out_data_d  = ld_val;
            out_inst_d  = bus.in_inst;
            out_fault_d = 1'b0;
        end else if (bus.in_valid) begin
            if (is_ld && !mis) begin
                state_d = LOAD_WAIT;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = mis ? '0 : bus.in_alu;
                out_inst_d  = bus.in_inst;
                out_fault_d = mis;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_inst_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_inst_q  <= out_inst_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign bus.stall     = idle_go && is_ld && !mis;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_fault = out_fault_q;
endmodule
